// File: rtl/half_adder.sv
// half_adder: registered per-bit sum/carry with a one-cycle valid pipeline
// and a wrapping count of accepted operations that produced any carry.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] cout,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);
    logic [WIDTH-1:0] out_q, out_d, cout_q, cout_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        out_d   = in_valid ? in1 ^ in2 : out_q;
        cout_d  = in_valid ? in1 & in2 : cout_q;
        valid_d = in_valid;
        cnt_d   = cnt_q + CNT_W'(in_valid && |(in1 & in2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            cout_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
    assign carry_cnt = cnt_q;
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: randomized and directed checks of an 8-bit/2-bit-counter
// instance and a 1-bit/8-bit-counter instance against an arithmetic model.
module tb_half_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       v = 1'b0;
    logic [7:0] out8, cout8;
    logic       ov8;
    logic [1:0] cnt8;
    logic       out1, cout1, ov1;
    logic [7:0] cnt1;
    int         errors = 0, checks = 0;
    logic [7:0] e_out8 = '0, e_cout8 = '0;
    logic       e_out1 = 1'b0, e_cout1 = 1'b0, e_v = 1'b0;
    int         e_cnt8 = 0, e_cnt1 = 0;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(8), .CNT_W(2)) u_dut8 (
        .clk(clk), .rst(rst), .in1(a), .in2(b), .in_valid(v),
        .out(out8), .cout(cout8), .out_valid(ov8), .carry_cnt(cnt8)
    );

    half_adder #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in1(a[0:0]), .in2(b[0:0]), .in_valid(v),
        .out(out1), .cout(cout1), .out_valid(ov1), .carry_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out8"}, 64'(out8), 64'(e_out8));
        chk({tag, ".cout8"}, 64'(cout8), 64'(e_cout8));
        chk({tag, ".ov8"}, 64'(ov8), 64'(e_v));
        chk({tag, ".cnt8"}, 64'(cnt8), 64'(e_cnt8));
        chk({tag, ".out1"}, 64'(out1), 64'(e_out1));
        chk({tag, ".cout1"}, 64'(cout1), 64'(e_cout1));
        chk({tag, ".ov1"}, 64'(ov1), 64'(e_v));
        chk({tag, ".cnt1"}, 64'(cnt1), 64'(e_cnt1));
    endtask

    // Model: each bit pair is added as two integers; sum bit is the LSB, carry the MSB.
    task automatic model(input logic [7:0] x, input logic [7:0] y, input logic val);
        logic [1:0] s;
        e_v = val;
        if (val) begin
            for (int i = 0; i < 8; i++) begin
                s = {1'b0, x[i]} + {1'b0, y[i]};
                e_out8[i]  = s[0];
                e_cout8[i] = s[1];
            end
            if (e_cout8 != 0) e_cnt8 = (e_cnt8 + 1) % 4;
            e_out1  = e_out8[0];
            e_cout1 = e_cout8[0];
            if (e_cout1) e_cnt1 = (e_cnt1 + 1) % 256;
        end
    endtask

    task automatic step(input logic [7:0] x, input logic [7:0] y, input logic val, input string tag);
        a = x;
        b = y;
        v = val;
        @(posedge clk);
        #1;
        model(x, y, val);
        chk_all(tag);
    endtask

    task automatic model_reset();
        e_out8 = '0; e_cout8 = '0; e_v = 1'b0; e_cnt8 = 0;
        e_out1 = 1'b0; e_cout1 = 1'b0; e_cnt1 = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        chk_all({tag, ".async"});
        a = 8'hFF;
        b = 8'hFF;
        v = 1'b1;
        @(posedge clk);
        #1;
        chk_all({tag, ".held"});
        rst = 1'b0;
        step(8'h00, 8'h00, 1'b0, {tag, ".post"});
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk_all("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h00, 8'h00, 1'b0, "idle");

        step(8'h00, 8'h00, 1'b1, "tt00");
        step(8'h00, 8'h01, 1'b1, "tt01");
        step(8'h01, 8'h00, 1'b1, "tt10");
        step(8'h01, 8'h01, 1'b1, "tt11");
        chk("tt.cnt1_end", 64'(cnt1), 64'd1);
        chk("tt.cout1_last", 64'(cout1), 64'd1);

        step(8'hF0, 8'h3C, 1'b1, "vec");
        chk("vec.out", 64'(out8), 64'hCC);
        chk("vec.cout", 64'(cout8), 64'h30);
        step(8'h55, 8'hAA, 1'b0, "vec.hold1");
        chk("vec.hold_out", 64'(out8), 64'hCC);
        step(8'hFF, 8'hFF, 1'b0, "vec.hold2");

        do_reset("rA");
        for (int i = 1; i <= 5; i++) begin
            step(8'h01, 8'h01, 1'b1, "wrap");
            chk("wrap.seq", 64'(cnt8), 64'(i % 4));
        end

        step(8'h01, 8'h00, 1'b1, "gap1");
        step(8'h01, 8'h01, 1'b0, "gap0");
        chk("gap.cnt_kept", 64'(cnt8), 64'd1);
        step(8'h00, 8'h01, 1'b1, "gap2");

        step(8'h01, 8'h01, 1'b1, "pre_rst");
        do_reset("rB");

        for (int i = 0; i < 300; i++)
            step(8'($urandom), 8'($urandom), ($urandom_range(3) != 0), "rnd");

        a = 8'h03;
        b = 8'h03;
        v = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("midrst");
        v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h00, 8'h00, 1'b0, "midrst.post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand width in bits, legal range 1 to 64.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the carry event counter, legal range 1 to 32.

Ports:
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in1  input  WIDTH  operand A.
REQ-006 in2  input  WIDTH  operand B.
REQ-007 in_valid  input  1  qualifies in1/in2 for capture this cycle.
REQ-008 out  output  WIDTH  registered sum bits, in1 XOR in2 per bit.
REQ-009 cout  output  WIDTH  registered carry bits, in1 AND in2 per bit.
REQ-010 out_valid  output  1  high for exactly the cycle(s) in which out/cout hold a newly captured result.
REQ-011 carry_cnt  output  CNT_W  count of accepted operations with any carry bit set.

Function
REQ-012 The block SHALL compute each bit i independently: out[i] = in1[i] XOR in2[i] and cout[i] = in1[i] AND in2[i], with no carry propagation between bits.
REQ-013 The block SHALL capture results on the rising clk edge where in_valid=1, giving a latency of exactly 1 cycle from in_valid to out_valid.
REQ-014 The block SHALL assert out_valid in the cycle after every in_valid=1 cycle and deassert it after every in_valid=0 cycle; back-to-back valid inputs SHALL give a continuous out_valid stream with no bubbles.
REQ-015 When in_valid=0, the block SHALL hold out and cout at their last captured values.
REQ-016 The block SHALL increment carry_cnt by 1 on each accepted input whose computed cout is non-zero.
REQ-017 carry_cnt SHALL wrap from all-ones to 0 with no saturation and no flag.
REQ-018 Inputs with X/Z are not supported; outputs SHALL be driven only from registers, with no combinational path from inputs to outputs.
REQ-019 The truth table per bit SHALL be: 0,0->sum 0,carry 0; 0,1->1,0; 1,0->1,0; 1,1->0,1.

Reset
REQ-020 While rst=1, the block SHALL immediately force out, cout, out_valid and carry_cnt to 0, independent of clk.
REQ-021 The block SHALL ignore in_valid while rst=1.
REQ-022 The first capture after reset SHALL occur on the first rising clk edge where rst=0 and in_valid=1.
REQ-023 If rst asserts mid-operation, any in-flight result SHALL be discarded and out_valid SHALL not pulse for it after release.

Verification
REQ-024 Exhaustive 1-bit vectors (WIDTH=1), in_valid=1 each cycle, sequence (0,0),(0,1),(1,0),(1,1) -> one cycle later out/cout = 0/0, 1/0, 1/0, 0/1, and carry_cnt ends at 1.
REQ-025 WIDTH=8, in1=8'hF0, in2=8'h3C, in_valid for one cycle -> out=8'hCC, cout=8'h30, out_valid high for exactly one cycle, then values held while in_valid=0.
REQ-026 Wrap test, CNT_W=2: five accepted inputs with in1=in2=1 -> carry_cnt sequence 1,2,3,0,1.
REQ-027 Asynchronous reset: assert rst between clock edges after a valid (1,1) input -> out, cout, out_valid and carry_cnt read 0 before the next edge; no out_valid pulse after release.
REQ-028 Gap handling: in_valid pattern 1,0,1 with inputs (1,0),(1,1),(0,1) -> out_valid pattern 1,0,1; the ignored (1,1) does not change carry_cnt.
